// File: rtl/rv_multicycle_control_if.sv
// ---------------------------------------------------------------------------
// rv_multicycle_control_if
// Instruction- and data-bus handshake between the multi-cycle control unit
// (master) and the memory system (slave).
//
// Handshake: a request (imem_req / dmem_req) rises when the master wants a
// transfer and is held, together with dmem_we and dmem_type, until the slave
// answers with a one-cycle ack. The transfer completes in the cycle where
// req && ack are both high. The ack may come in the first request cycle.
// imem_rdata only needs to be valid in the imem_ack cycle. The master drops
// the request in the cycle after the ack, or at once on reset.
//
// Signals:
//   imem_req   master->slave  instruction fetch request
//   imem_ack   slave->master  fetch complete
//   imem_rdata slave->master  fetched instruction word
//   dmem_req   master->slave  data access request
//   dmem_we    master->slave  1 = store, 0 = load
//   dmem_type  master->slave  funct3 width/sign code
//   dmem_ack   slave->master  data access complete
// ---------------------------------------------------------------------------
interface rv_multicycle_control_if;
   logic        imem_req;
   logic        imem_ack;
   logic [31:0] imem_rdata;
   logic        dmem_req;
   logic        dmem_we;
   logic [2:0]  dmem_type;
   logic        dmem_ack;

   modport master (
      output imem_req,
      input  imem_ack,
      input  imem_rdata,
      output dmem_req,
      output dmem_we,
      output dmem_type,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      output imem_ack,
      output imem_rdata,
      input  dmem_req,
      input  dmem_we,
      input  dmem_type,
      output dmem_ack
   );
endinterface

// File: rtl/rv_multicycle_control.sv
// ---------------------------------------------------------------------------
// rv_multicycle_control
// Multi-cycle RV32I control unit. Sequences IDLE/FETCH/DECODE/EXEC/MEM/WB/
// TRAP, owns the instruction register, watches bus timeouts and takes
// prioritised external interrupts at instruction boundaries.
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-low reset
//   bus               instruction/data bus handshakes (master side)
//   irq, mie          level-sensitive interrupt lines, global enable
//   ir                instruction register
//   imm_sel           0 I, 1 S, 2 B, 3 U, 4 J immediate format
//   alu_src_b         1 = ALU operand B is the immediate
//   mem_to_reg        0 ALU result, 1 load data, 2 PC+4
//   alu_ctrl          {funct7[5], funct3} for ALU ops; 1000 sub (beq/bne),
//                     0010 slt (blt/bge), 0011 sltu (bltu/bgeu), 1111 pass B
//   jump, branch      JAL/JALR, conditional branch
//   inverse_branch    take the branch when the compare is false (bne/bge/bgeu)
//   pc_offset         1 = ALU operand A is the PC (AUIPC, JAL target)
//   reg_we, pc_we     register file / PC write strobes
//   retire            one pulse per completed instruction
//   trap, trap_cause, trap_is_irq, irq_id   trap entry and its reason
//   mret              return from trap
//   dbg_state         current FSM state
// ---------------------------------------------------------------------------
module rv_multicycle_control #(
   parameter int NUM_IRQ        = 4,
   parameter int TIMEOUT_CYCLES = 255,
   localparam int IRQ_W         = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
   input  logic                   clk,
   input  logic                   rst,
   rv_multicycle_control_if.master bus,
   input  logic [NUM_IRQ-1:0]     irq,
   input  logic                   mie,
   output logic [31:0]            ir,
   output logic [2:0]             imm_sel,
   output logic                   alu_src_b,
   output logic [1:0]             mem_to_reg,
   output logic [3:0]             alu_ctrl,
   output logic                   jump,
   output logic                   branch,
   output logic                   inverse_branch,
   output logic                   pc_offset,
   output logic                   reg_we,
   output logic                   pc_we,
   output logic                   retire,
   output logic                   trap,
   output logic [3:0]             trap_cause,
   output logic                   trap_is_irq,
   output logic [IRQ_W-1:0]       irq_id,
   output logic                   mret,
   output logic [2:0]             dbg_state
);
   typedef enum logic [2:0] {
      S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

   state_t           state_q, state_d;
   logic [31:0]      ir_q, ir_d;
   logic [15:0]      cnt_q, cnt_d;
   logic             started_q, started_d;
   logic [3:0]       cause_q, cause_d;
   logic             is_irq_q, is_irq_d;
   logic [IRQ_W-1:0] irq_id_q, irq_id_d;

   logic [6:0]       opcode;
   logic [2:0]       funct3;
   logic             known_opc, is_load, is_store, is_branch;
   logic             is_ecall, is_mret, is_legal;
   logic             timed_out, irq_pending, retire_chk, fault;
   logic [3:0]       fault_cause;
   logic [IRQ_W-1:0] irq_sel;

   assign opcode    = ir_q[6:0];
   assign funct3    = ir_q[14:12];
   assign is_load   = (opcode == OPC_LOAD);
   assign is_store  = (opcode == OPC_STORE);
   assign is_branch = (opcode == OPC_BRANCH);
   assign is_ecall  = (opcode == OPC_SYSTEM) && (ir_q[31:20] == 12'h000);
   assign is_mret   = (opcode == OPC_SYSTEM) && (ir_q[31:20] == 12'h302);
   assign is_legal  = known_opc && ((opcode != OPC_SYSTEM) || is_ecall || is_mret);

   // Datapath selects, a pure function of the instruction register.
   always_comb begin
      imm_sel        = 3'd0;
      alu_src_b      = 1'b0;
      mem_to_reg     = 2'd0;
      alu_ctrl       = 4'b0000;
      jump           = 1'b0;
      branch         = 1'b0;
      inverse_branch = 1'b0;
      pc_offset      = 1'b0;
      known_opc      = 1'b1;
      case (opcode)
         OPC_OP:    alu_ctrl = {ir_q[30], funct3};
         OPC_IMM: begin
            alu_src_b = 1'b1;
            // funct7[5] only distinguishes srai from srli among immediates
            alu_ctrl  = {(funct3 == 3'b101) & ir_q[30], funct3};
         end
         OPC_LOAD: begin
            alu_src_b  = 1'b1;
            mem_to_reg = 2'd1;
         end
         OPC_STORE: begin
            imm_sel   = 3'd1;
            alu_src_b = 1'b1;
         end
         OPC_BRANCH: begin
            imm_sel        = 3'd2;
            branch         = 1'b1;
            inverse_branch = funct3[0];
            alu_ctrl       = funct3[2] ? {3'b001, funct3[1]} : 4'b1000;
         end
         OPC_LUI: begin
            imm_sel   = 3'd3;
            alu_src_b = 1'b1;
            alu_ctrl  = 4'b1111;
         end
         OPC_AUIPC: begin
            imm_sel   = 3'd3;
            alu_src_b = 1'b1;
            pc_offset = 1'b1;
         end
         OPC_JAL: begin
            imm_sel    = 3'd4;
            alu_src_b  = 1'b1;
            pc_offset  = 1'b1;
            jump       = 1'b1;
            mem_to_reg = 2'd2;
         end
         OPC_JALR: begin
            alu_src_b  = 1'b1;
            jump       = 1'b1;
            mem_to_reg = 2'd2;
         end
         OPC_SYSTEM: known_opc = 1'b1;
         default:    known_opc = 1'b0;
      endcase
   end

   // Lowest-numbered active line wins.
   always_comb begin
      irq_sel = '0;
      for (int i = NUM_IRQ - 1; i >= 0; i--) begin
         if (irq[i]) irq_sel = IRQ_W'(i);
      end
   end

   assign irq_pending = mie & (|irq);
   assign timed_out   = (cnt_q == TMO_LAST);

   // Strobes are decoded from the registered state; the store retires in its
   // ack cycle, so these cannot be registered ahead of time.
   assign bus.imem_req  = (state_q == S_FETCH);
   assign bus.dmem_req  = (state_q == S_MEM);
   assign bus.dmem_we   = (state_q == S_MEM) && is_store;
   assign bus.dmem_type = (state_q == S_MEM) ? funct3 : 3'b000;

   assign mret   = (state_q == S_DECODE) && is_legal && is_mret;
   assign retire = mret
                || ((state_q == S_EXEC) && !is_load && !is_store)
                || ((state_q == S_MEM) && bus.dmem_ack && is_store)
                || (state_q == S_WB);
   assign reg_we = ((state_q == S_EXEC) && !is_load && !is_store && !is_branch)
                || (state_q == S_WB);
   assign trap   = (state_q == S_TRAP);
   assign pc_we  = retire || trap;

   // mret returns straight to FETCH; every other retirement is a boundary
   // where a pending interrupt may be taken.
   assign retire_chk = retire && !mret;

   always_comb begin
      state_d     = state_q;
      ir_d        = ir_q;
      cnt_d       = cnt_q;
      started_d   = 1'b1;
      cause_d     = cause_q;
      is_irq_d    = is_irq_q;
      irq_id_d    = irq_id_q;
      fault       = 1'b0;
      fault_cause = 4'd0;
      case (state_q)
         // One extra IDLE cycle so the first fetch goes out on the second
         // edge after reset release.
         S_IDLE: if (started_q) state_d = S_FETCH;
         S_FETCH: begin
            if (bus.imem_ack) begin
               ir_d    = bus.imem_rdata;
               state_d = S_DECODE;
            end else if (timed_out) begin
               fault       = 1'b1;
               fault_cause = 4'd1;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_DECODE: begin
            if (!is_legal) begin
               fault       = 1'b1;
               fault_cause = 4'd2;
            end else if (is_ecall) begin
               fault       = 1'b1;
               fault_cause = 4'd11;
            end else if (is_mret) begin
               state_d = S_FETCH;
            end else begin
               state_d = S_EXEC;
            end
         end
         S_EXEC: if (is_load || is_store) state_d = S_MEM;
         S_MEM: begin
            if (bus.dmem_ack) begin
               if (is_load) state_d = S_WB;
            end else if (timed_out) begin
               fault       = 1'b1;
               fault_cause = is_store ? 4'd7 : 4'd5;
            end else begin
               cnt_d = cnt_q + 16'd1;
            end
         end
         S_TRAP:  state_d = S_FETCH;
         default: state_d = state_q;
      endcase

      if (fault) begin
         state_d  = S_TRAP;
         cause_d  = fault_cause;
         is_irq_d = 1'b0;
         irq_id_d = '0;
      end
      if (retire_chk) begin
         if (irq_pending) begin
            state_d  = S_TRAP;
            cause_d  = 4'd11;
            is_irq_d = 1'b1;
            irq_id_d = irq_sel;
         end else begin
            state_d = S_FETCH;
         end
      end
      if ((state_d != state_q) && ((state_d == S_FETCH) || (state_d == S_MEM))) begin
         cnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= S_IDLE;
         ir_q      <= 32'h00000013;
         cnt_q     <= '0;
         started_q <= 1'b0;
         cause_q   <= 4'd0;
         is_irq_q  <= 1'b0;
         irq_id_q  <= '0;
      end else begin
         state_q   <= state_d;
         ir_q      <= ir_d;
         cnt_q     <= cnt_d;
         started_q <= started_d;
         cause_q   <= cause_d;
         is_irq_q  <= is_irq_d;
         irq_id_q  <= irq_id_d;
      end
   end

   assign ir          = ir_q;
   assign trap_cause  = cause_q;
   assign trap_is_irq = is_irq_q;
   assign irq_id      = irq_id_q;
   assign dbg_state   = state_q;
endmodule
